// File: rtl/text_ram_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the text RAM arbiter.
// The slave view belongs to the arbiter; the master view belongs to the environment.
interface text_ram_arbiter_if #(
    parameter int A = 10,
    parameter int D = 8
);
    logic         vid_req;
    logic [A-1:0] vid_addr;
    logic         vid_valid;
    logic [D-1:0] vid_data;
    logic         cpu_req;
    logic         cpu_we;
    logic [A-1:0] cpu_addr;
    logic [D-1:0] cpu_din;
    logic         cpu_ack;
    logic [D-1:0] cpu_dout;
    logic         clr_start;
    logic [D-1:0] clr_char;
    logic         clr_done;
    logic         busy;
    logic         ram_we;
    logic [A-1:0] ram_addr;
    logic [D-1:0] ram_din;
    logic [D-1:0] ram_dout;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
               clr_start, clr_char, ram_dout,
        output vid_valid, vid_data, cpu_ack, cpu_dout, clr_done, busy,
               ram_we, ram_addr, ram_din
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
               clr_start, clr_char, ram_dout,
        input  vid_valid, vid_data, cpu_ack, cpu_dout, clr_done, busy,
               ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/text_ram_arbiter.sv
// Shares the single text RAM port between video scanout, the clear engine and the CPU.
// Fixed priority video > clear > CPU; read data returns one cycle after each grant.
module text_ram_arbiter #(
    parameter int A = 10,
    parameter int D = 8
) (
    input  logic                clk,
    input  logic                reset,
    text_ram_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic [A-1:0] clr_cnt_r;
    logic [A-1:0] clr_cnt_s;
    logic [D-1:0] clr_char_r;
    logic [D-1:0] clr_char_s;
    logic         clr_done_r;
    logic         clr_done_s;
    logic         vid_valid_r;
    logic         cpu_ack_r;

    logic         vid_gnt_s;
    logic         clr_gnt_s;
    logic         cpu_gnt_s;
    logic         ram_we_s;
    logic [A-1:0] ram_addr_s;
    logic [D-1:0] ram_din_s;

    // Per-cycle grant decision; cpu_ack_r doubles as the CPU in-flight flag.
    always_comb begin
        vid_gnt_s = 1'b0;
        clr_gnt_s = 1'b0;
        cpu_gnt_s = 1'b0;
        if (bus.vid_req) begin
            vid_gnt_s = 1'b1;
        end else if (state_r == CLEAR) begin
            clr_gnt_s = 1'b1;
        end else if (bus.cpu_req && !cpu_ack_r) begin
            cpu_gnt_s = 1'b1;
        end else begin
            vid_gnt_s = 1'b0;
        end
    end

    // RAM port steering for whichever requester holds the grant.
    always_comb begin
        ram_we_s   = 1'b0;
        ram_addr_s = bus.vid_addr;
        ram_din_s  = bus.cpu_din;
        if (vid_gnt_s) begin
            ram_addr_s = bus.vid_addr;
        end else if (clr_gnt_s) begin
            ram_we_s   = 1'b1;
            ram_addr_s = clr_cnt_r;
            ram_din_s  = clr_char_r;
        end else if (cpu_gnt_s) begin
            ram_we_s   = bus.cpu_we;
            ram_addr_s = bus.cpu_addr;
            ram_din_s  = bus.cpu_din;
        end else begin
            ram_we_s   = 1'b0;
        end
    end

    // Clear engine next state: video steals hold the counter, all-ones ends the sweep.
    always_comb begin
        state_s    = state_r;
        clr_cnt_s  = clr_cnt_r;
        clr_char_s = clr_char_r;
        clr_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.clr_start) begin
                    clr_char_s = bus.clr_char;
                    clr_cnt_s  = {A{1'b0}};
                    state_s    = CLEAR;
                end else begin
                    state_s    = IDLE;
                end
            end
            CLEAR: begin
                if (clr_gnt_s) begin
                    if (clr_cnt_r == {A{1'b1}}) begin
                        state_s    = IDLE;
                        clr_done_s = 1'b1;
                    end else begin
                        clr_cnt_s  = clr_cnt_r + {{(A-1){1'b0}}, 1'b1};
                    end
                end else begin
                    clr_cnt_s = clr_cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and response flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            clr_cnt_r   <= {A{1'b0}};
            clr_char_r  <= {D{1'b0}};
            clr_done_r  <= 1'b0;
            vid_valid_r <= 1'b0;
            cpu_ack_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            clr_cnt_r   <= clr_cnt_s;
            clr_char_r  <= clr_char_s;
            clr_done_r  <= clr_done_s;
            vid_valid_r <= vid_gnt_s;
            cpu_ack_r   <= cpu_gnt_s;
        end
    end

    // Read data is the RAM's own registered output, so it is passed straight through.
    assign bus.vid_valid = vid_valid_r;
    assign bus.vid_data  = bus.ram_dout;
    assign bus.cpu_ack   = cpu_ack_r;
    assign bus.cpu_dout  = cpu_ack_r ? bus.ram_dout : {D{1'b0}};
    assign bus.clr_done  = clr_done_r;
    assign bus.busy      = (state_r == CLEAR);
    assign bus.ram_we    = ram_we_s & ~reset;
    assign bus.ram_addr  = ram_addr_s;
    assign bus.ram_din   = ram_din_s;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Directed plus randomized bench for text_ram_arbiter with a behavioural RAM and a
// reference memory image that tracks what every address should hold.
module tb_text_ram_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic init_mem;

    always #5 clk = ~clk;

    text_ram_arbiter_if #(.A(10), .D(8)) bus ();

    text_ram_arbiter #(.A(10), .D(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];
    int n_chk;
    int n_fail;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 19);
    endfunction

    // Synchronous RAM with one-cycle registered read and a one-shot preload.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_din;
        end
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; any video read issued in the cycle must come back now.
    task automatic tick();
        logic       pv;
        logic [9:0] pa;
        pv = bus.vid_req;
        pa = bus.vid_addr;
        @(posedge clk);
        #1;
        if (!reset) begin
            check("vid_valid", 32'(bus.vid_valid), 32'(pv));
            if (pv) check("vid_data", 32'(bus.vid_data), 32'(ref_mem[pa]));
        end
    endtask

    task automatic readback_all();
        for (int i = 0; i < 1024; i++) begin
            bus.vid_req  = 1'b1;
            bus.vid_addr = 10'(i);
            tick();
        end
        bus.vid_req = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] fill2;
        logic [7:0] exp5;
        logic       v;
        logic       g;
        logic       we;
        logic       done;
        logic [9:0] addr;
        logic [7:0] din;
        int         c;
        int         ptr;
        int         cyc;

        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        init_mem = 1'b1;
        bus.vid_req = 1'b0;
        bus.vid_addr = 10'd0;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 10'd0;
        bus.cpu_din = 8'd0;
        bus.clr_start = 1'b0;
        bus.clr_char = 8'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
        tick();
        tick();
        init_mem = 1'b0;
        check("rst_vid_valid", 32'(bus.vid_valid), 32'd0);
        check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("rst_clr_done", 32'(bus.clr_done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ram_we", 32'(bus.ram_we), 32'd0);
        check("rst_cpu_dout", 32'(bus.cpu_dout), 32'd0);
        reset = 1'b0;
        tick();

        // Reset mid-traffic: video result pending and a CPU write granted.
        bus.vid_req = 1'b1;
        bus.vid_addr = 10'd3;
        tick();
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 10'h3FF;
        bus.cpu_din = 8'hEE;
        #1;
        check("pre_rst_ram_we", 32'(bus.ram_we), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_ram_we", 32'(bus.ram_we), 32'd0);
        check("arst_vid_valid", 32'(bus.vid_valid), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_clr_done", 32'(bus.clr_done), 32'd0);
        check("arst_cpu_dout", 32'(bus.cpu_dout), 32'd0);
        bus.cpu_req = 1'b0;
        tick();
        check("arst_no_ack", 32'(bus.cpu_ack), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_no_ack", 32'(bus.cpu_ack), 32'd0);
        bus.vid_req = 1'b1;
        bus.vid_addr = 10'h3FF;
        tick();
        bus.vid_req = 1'b0;
        tick();

        // CPU write 0x41 to 0x005, then read it back.
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 10'h005;
        bus.cpu_din = 8'h41;
        #1;
        check("wr_ram_we", 32'(bus.ram_we), 32'd1);
        check("wr_ram_addr", 32'(bus.ram_addr), 32'h005);
        check("wr_ram_din", 32'(bus.ram_din), 32'h41);
        tick();
        check("wr_ack", 32'(bus.cpu_ack), 32'd1);
        bus.cpu_req = 1'b0;
        ref_mem[5] = 8'h41;
        tick();
        check("wr_ack_pulse", 32'(bus.cpu_ack), 32'd0);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        #1;
        check("rd_ram_we", 32'(bus.ram_we), 32'd0);
        tick();
        check("rd_ack", 32'(bus.cpu_ack), 32'd1);
        check("rd_dout", 32'(bus.cpu_dout), 32'h41);
        bus.cpu_req = 1'b0;
        tick();

        // Video and CPU in the same cycle: video first, CPU the cycle after.
        bus.vid_req = 1'b1;
        bus.vid_addr = 10'h010;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 10'h005;
        #1;
        check("cf_ram_addr_vid", 32'(bus.ram_addr), 32'h010);
        check("cf_ram_we", 32'(bus.ram_we), 32'd0);
        tick();
        check("cf_no_ack", 32'(bus.cpu_ack), 32'd0);
        bus.vid_req = 1'b0;
        #1;
        check("cf_ram_addr_cpu", 32'(bus.ram_addr), 32'h005);
        tick();
        check("cf_ack", 32'(bus.cpu_ack), 32'd1);
        check("cf_dout", 32'(bus.cpu_dout), 32'h41);
        bus.cpu_req = 1'b0;
        tick();

        // Video holds the port for 50 cycles while the CPU waits.
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 10'h010;
        for (int i = 0; i < 50; i++) begin
            bus.vid_req = 1'b1;
            bus.vid_addr = 10'($urandom_range(0, 1023));
            tick();
            check("starve_no_ack", 32'(bus.cpu_ack), 32'd0);
        end
        bus.vid_req = 1'b0;
        tick();
        check("starve_ack", 32'(bus.cpu_ack), 32'd1);
        check("starve_dout", 32'(bus.cpu_dout), 32'(ref_mem[16]));
        bus.cpu_req = 1'b0;
        tick();

        // Full clear with 0x20 and no video traffic.
        bus.clr_char = 8'h20;
        bus.clr_start = 1'b1;
        #1;
        check("clr_busy_start", 32'(bus.busy), 32'd0);
        tick();
        bus.clr_start = 1'b0;
        bus.clr_char = 8'hFF;
        #1;
        for (int k = 0; k < 1024; k++) begin
            check("clr_busy", 32'(bus.busy), 32'd1);
            check("clr_ram_we", 32'(bus.ram_we), 32'd1);
            check("clr_ram_addr", 32'(bus.ram_addr), 32'(k));
            check("clr_ram_din", 32'(bus.ram_din), 32'h20);
            check("clr_done_early", 32'(bus.clr_done), 32'd0);
            tick();
        end
        check("clr_done", 32'(bus.clr_done), 32'd1);
        check("clr_busy_end", 32'(bus.busy), 32'd0);
        tick();
        check("clr_done_pulse", 32'(bus.clr_done), 32'd0);
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h20;
        readback_all();

        // Second clear: CPU read alongside clr_start, 10 video steals, CPU parked until done.
        fill2 = 8'($urandom_range(33, 255));
        bus.clr_char = fill2;
        bus.clr_start = 1'b1;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 10'h005;
        exp5 = ref_mem[5];
        #1;
        check("clr2_cpu_gnt_addr", 32'(bus.ram_addr), 32'h005);
        check("clr2_cpu_gnt_we", 32'(bus.ram_we), 32'd0);
        tick();
        bus.clr_start = 1'b0;
        bus.clr_char = ~fill2;
        c = 1;
        ptr = 0;
        while (!bus.clr_done && c < 1100) begin
            if (c == 1) begin
                check("clr2_ack", 32'(bus.cpu_ack), 32'd1);
                check("clr2_dout", 32'(bus.cpu_dout), 32'(exp5));
                bus.cpu_req = 1'b0;
            end else begin
                check("clr2_no_ack", 32'(bus.cpu_ack), 32'd0);
            end
            if (c == 2) begin
                bus.cpu_req = 1'b1;
                bus.cpu_addr = 10'h123;
            end
            v = ((c % 50) == 7) && (c < 500);
            bus.vid_req = v;
            bus.vid_addr = ((c % 100) == 7) ? 10'(ptr - 1) : 10'(ptr);
            if (!v && ptr < 1024) begin
                ref_mem[ptr] = fill2;
                ptr++;
            end
            tick();
            c++;
        end
        check("clr2_done_cycle", 32'(c), 32'd1035);
        check("clr2_done", 32'(bus.clr_done), 32'd1);
        bus.vid_req = 1'b0;
        tick();
        check("clr2_cpu_after", 32'(bus.cpu_ack), 32'd1);
        check("clr2_cpu_dout", 32'(bus.cpu_dout), 32'(fill2));
        bus.cpu_req = 1'b0;
        tick();
        check("clr2_done_pulse", 32'(bus.clr_done), 32'd0);

        // Random CPU traffic under random video load.
        for (int op = 0; op < 150; op++) begin
            we = 1'($urandom_range(0, 1));
            addr = 10'($urandom_range(0, 15));
            din = 8'($urandom_range(0, 255));
            bus.cpu_req = 1'b1;
            bus.cpu_we = we;
            bus.cpu_addr = addr;
            bus.cpu_din = din;
            done = 1'b0;
            cyc = 0;
            while (!done && cyc < 100) begin
                v = ($urandom_range(0, 2) != 0);
                bus.vid_req = v;
                bus.vid_addr = 10'($urandom_range(0, 15));
                g = !v;
                tick();
                cyc++;
                check("rnd_ack", 32'(bus.cpu_ack), 32'(g));
                if (bus.cpu_ack) begin
                    done = 1'b1;
                    if (we) ref_mem[addr] = din;
                    else check("rnd_dout", 32'(bus.cpu_dout), 32'(ref_mem[addr]));
                end
            end
            check("rnd_timeout", 32'(done), 32'd1);
            bus.cpu_req = 1'b0;
            bus.vid_req = 1'($urandom_range(0, 1));
            bus.vid_addr = 10'($urandom_range(0, 15));
            tick();
        end
        bus.vid_req = 1'b0;
        tick();

        // Reset in the middle of a clear, when the counter reaches 0x100.
        init_mem = 1'b1;
        tick();
        init_mem = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
        bus.clr_char = 8'h20;
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        for (int k = 0; k < 256; k++) tick();
        #1;
        check("mid_ram_addr", 32'(bus.ram_addr), 32'h100);
        check("mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_ram_we", 32'(bus.ram_we), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        tick();
        check("mid_rst_done", 32'(bus.clr_done), 32'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_no_done", 32'(bus.clr_done), 32'd0);
            check("mid_idle", 32'(bus.busy), 32'd0);
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h20;
        readback_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/text_ram_arbiter.md
# text_ram_arbiter

Single-port access controller for the text-mode video RAM. It shares one synchronous RAM port among three requesters: the video scanout fetcher (hard real-time), a hardware screen-clear engine, and the CPU bus. It sits between those requesters and the text RAM instance, drives all of the RAM's address, write-enable and data inputs, and returns read data to the requester that issued each access.

## Interface

Parameters
- `A`, 10, RAM address width; depth is `1<<A` words.
- `D`, 8, RAM data width.

Ports
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `vid_req`  in  1  video read request, valid for this cycle only (no hold).
- `vid_addr`  in  A  video read address.
- `vid_valid`  out  1  video read data valid.
- `vid_data`  out  D  video read data.
- `cpu_req`  in  1  CPU access request; held high until `cpu_ack`.
- `cpu_we`  in  1  CPU access is a write when 1, a read when 0.
- `cpu_addr`  in  A  CPU address.
- `cpu_din`  in  D  CPU write data.
- `cpu_ack`  out  1  one-cycle pulse that completes a CPU access.
- `cpu_dout`  out  D  CPU read data; valid while `cpu_ack` is high.
- `clr_start`  in  1  pulse; starts a clear of the whole RAM.
- `clr_char`  in  D  fill value; sampled together with `clr_start`.
- `clr_done`  out  1  one-cycle pulse when a clear completes.
- `busy`  out  1  high while a clear is in progress.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  A  RAM address.
- `ram_din`  out  D  RAM write data.
- `ram_dout`  in  D  RAM registered read data; valid one cycle after its address is presented.

## Operation

**Per-cycle grant.** One grant per cycle, decided combinationally. Priority order:
1. Video, whenever `vid_req` is high.
2. Clear, when the clear FSM is in CLEAR.
3. CPU, when `cpu_req` is high, no CPU access is in flight, and the FSM is in IDLE.

**Outputs of the grant.**
- Video grant: `ram_addr = vid_addr`, `ram_we = 0`.
- Clear grant: `ram_addr = clr_cnt`, `ram_din = clr_char_q`, `ram_we = 1`.
- CPU grant: `ram_addr = cpu_addr`, `ram_din = cpu_din`, `ram_we = cpu_we`.
- No grant: `ram_we = 0`. `ram_addr` and `ram_din` are don't-care.

**CPU in-flight flag.**
- Set on the cycle of a CPU grant.
- Cleared on the next cycle, which is the `cpu_ack` cycle.
- A CPU access is therefore never granted twice, and CPU throughput is at most one access per 2 cycles.

**Clear FSM.**
- IDLE: on `clr_start`, latch `clr_char_q <= clr_char`, set `clr_cnt <= 0`, and go to CLEAR.
- CLEAR: on each clear grant, write `clr_char_q` to address `clr_cnt`.
  - If `clr_cnt` is all-ones, go to IDLE and assert `clr_done` next cycle.
  - Otherwise increment `clr_cnt`.
  - Cycles stolen by video hold `clr_cnt` unchanged.
- `clr_start` is ignored while in CLEAR.
- `busy = (state == CLEAR)`.
- CPU requests are not granted during CLEAR; `cpu_req` simply waits.

**Arithmetic.** `clr_cnt` is A bits wide. Terminal detection uses all-ones, so it never wraps past the last address.

## Timing

- Reset values: `vid_valid = 0`, `cpu_ack = 0`, `clr_done = 0`, `busy = 0`, state IDLE, `clr_cnt = 0`, in-flight flag 0, `cpu_dout = 0`. While `reset` is high, `ram_we` is forced to 0.
- Read latency is 1 cycle. For a grant in cycle N:
  - Video grant: `vid_valid = 1` in N+1 and `vid_data = ram_dout` in N+1 (direct pass-through).
  - CPU grant (read or write): `cpu_ack = 1` in N+1. For a read, `cpu_dout = ram_dout` in N+1.
- `vid_valid` and `cpu_ack` come from registered grant flags. Video gets back-to-back reads every cycle.
- `clr_start` in cycle N:
  - The first clear write happens in N+1, at the earliest.
  - A CPU grant in N, in the same cycle as `clr_start`, is allowed and still acks in N+1.
- With no video traffic, the last write occurs in N+`(1<<A)` and `clr_done` pulses in N+`(1<<A)`+1. Each video grant delays this by one cycle.
- Simultaneous `vid_req` and `cpu_req`: video wins, and the CPU is granted on the first cycle with `vid_req` low.
- Reset mid-clear:
  - The clear aborts immediately with no `clr_done`.
  - Addresses below `clr_cnt` hold the fill value; the rest are unchanged.
  - A CPU access in flight at reset gets no ack.
- The CPU must not change `cpu_we`, `cpu_addr` or `cpu_din` while `cpu_req` is high and unacknowledged. It may reassert `cpu_req` in the cycle after the ack.

## Test plan

- **Reset:** assert `reset` mid-traffic. Expect all outputs at reset values and `ram_we = 0` with no clock edge.
- **CPU write then read:** write 0x41 to address 0x005 with `vid_req = 0`.
  - Expect `ram_we = 1` in grant cycle N and `cpu_ack` in N+1.
  - Then read 0x005. Expect `cpu_ack` with `cpu_dout = 0x41`.
- **Conflict:** `vid_req` (address 0x010) and `cpu_req` (read 0x005) in the same cycle N.
  - Expect `vid_valid` in N+1.
  - Expect the CPU granted in N+1 and `cpu_ack` in N+2.
- **Video starvation:** hold `vid_req` for 50 cycles with `cpu_req` high. Expect no `cpu_ack` in that window, then `cpu_ack` 2 cycles after `vid_req` falls.
- **Full clear:** `clr_start` with `clr_char = 0x20` and no video.
  - Expect `busy` for 1024 cycles and `clr_done` at start+1025.
  - Expect every address to read back 0x20.
  - Repeat with 10 interleaved video reads: `clr_done` at start+1035.
- **Reset mid-clear:** assert `reset` when `clr_cnt = 0x100`.
  - Expect no `clr_done`.
  - Expect addresses 0x000–0x0FF = 0x20 and 0x100–0x3FF unchanged.
